// File: rtl/uart2_pkgs.sv
// uart2_pkgs: shared UART receive types and constants.
// UART_DATA_BITS is also used by the downstream 8-to-64 collector.
package uart2_pkgs;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [1:0] {
        IDLE_STATE,
        START_STATE,
        MOVE_DATA_STATE,
        STOP_STATE
    } state_encoding;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
// Resets to 1 so an idle line does not look like a start bit.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_i,
    output logic rx_s_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_i};
    end
    assign rx_s_o = sync_q[1];
endmodule

// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer: oversampling 8N1 receiver with a one-entry valid/ready
// holding register; framing errors and overruns are reported as 1-cycle pulses.
module uart_rx_deserializer
    import uart2_pkgs::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);

    logic                 rx_s;
    state_encoding        state_q, state_d;
    logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .rx_i   (rx_i),
        .rx_s_o (rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE_STATE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q && !rx_ready_i;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE_STATE: begin
                if (!rx_s) begin
                    state_d   = START_STATE;
                    clk_cnt_d = '0;
                end
            end
            START_STATE: begin
                if (clk_cnt_q == HALF) begin
                    state_d   = rx_s ? IDLE_STATE : MOVE_DATA_STATE;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else clk_cnt_d = clk_cnt_q + 1'b1;
            end
            MOVE_DATA_STATE: begin
                if (clk_cnt_q == FULL) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST) state_d = STOP_STATE;
                end else clk_cnt_d = clk_cnt_q + 1'b1;
            end
            STOP_STATE: begin
                // Stop bit is sampled at its midpoint; the frame ends here.
                if (clk_cnt_q == FULL) begin
                    state_d   = IDLE_STATE;
                    clk_cnt_d = '0;
                    if (!rx_s) frame_err_d = 1'b1;
                    else if (!valid_q || rx_ready_i) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else overrun_d = 1'b1;
                end else clk_cnt_d = clk_cnt_q + 1'b1;
            end
            default: state_d = IDLE_STATE;
        endcase
    end

    assign rx_data_o   = data_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = state_q != IDLE_STATE;
endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer: directed serial frames with assertion-based checks
// on data, handshake, pulse widths and stop-sample latency.
module tb_uart_rx_deserializer;
    localparam int CPB = 16;
    // rx_i low -> rx_s low (2) -> IDLE sees it (1) -> half bit (8) -> 9 bits (144).
    localparam int LAT = 155;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_i = 1'b1;
    logic       rx_ready_i = 1'b1;
    logic [7:0] rx_data_o;
    logic       rx_valid_o, frame_err_o, overrun_o, busy_o;

    int errors = 0, checks = 0;
    int cyc = 0, vrise = 0, last_vrise = 0, vhigh = 0;
    int fe_n = 0, last_fe = 0, ov_n = 0, last_ov = 0;
    int t_start, r0, v0, h0, f0, o0;
    logic prev_v = 1'b0;

    uart_rx_deserializer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_i        (rx_i),
        .rx_data_o   (rx_data_o),
        .rx_valid_o  (rx_valid_o),
        .rx_ready_i  (rx_ready_i),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rx_valid_o && !prev_v) begin
            vrise++;
            last_vrise = cyc;
        end
        if (rx_valid_o) vhigh++;
        if (frame_err_o) begin
            fe_n++;
            last_fe = cyc;
        end
        if (overrun_o) begin
            ov_n++;
            last_ov = cyc;
        end
        prev_v = rx_valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        t_start = cyc;
        for (int i = 0; i < 10; i++) begin
            rx_i = f[i];
            repeat (CPB) @(negedge clk);
        end
        rx_i = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(rx_valid_o), 0);
        chk("rst_data", 32'(rx_data_o), 0);
        chk("rst_fe", 32'(frame_err_o), 0);
        chk("rst_ov", 32'(overrun_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: single frame, consumer ready
        send(8'hA5, 1'b1);
        chk("t1_data", 32'(rx_data_o), 32'hA5);
        chk("t1_vrise", 32'(vrise), 1);
        chk("t1_latency", 32'(last_vrise - t_start), LAT);
        chk("t1_vwidth", 32'(vhigh), 1);
        chk("t1_fe", 32'(fe_n), 0);
        chk("t1_ov", 32'(ov_n), 0);
        repeat (20) @(negedge clk);

        // 2: glitch shorter than half a bit
        rx_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_hi", 32'(busy_o), 1);
        rx_i = 1'b1;
        repeat (8) @(negedge clk);
        chk("t2_busy_lo", 32'(busy_o), 0);
        repeat (10) @(negedge clk);
        chk("t2_vrise", 32'(vrise), 1);
        chk("t2_fe", 32'(fe_n), 0);

        // 3: bad stop bit
        send(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        chk("t3_fe_cycles", 32'(fe_n), 1);
        chk("t3_fe_time", 32'(last_fe - t_start), LAT);
        chk("t3_vrise", 32'(vrise), 1);
        chk("t3_valid", 32'(rx_valid_o), 0);

        // 4: overrun while holding register is full
        rx_ready_i = 1'b0;
        send(8'h11, 1'b1);
        chk("t4_valid1", 32'(rx_valid_o), 1);
        chk("t4_data1", 32'(rx_data_o), 32'h11);
        send(8'h22, 1'b1);
        chk("t4_hold", 32'(rx_data_o), 32'h11);
        chk("t4_valid2", 32'(rx_valid_o), 1);
        chk("t4_ov_cycles", 32'(ov_n), 1);
        chk("t4_ov_time", 32'(last_ov - t_start), LAT);
        rx_ready_i = 1'b1;
        @(negedge clk);
        chk("t4_valid_fall", 32'(rx_valid_o), 0);
        chk("t4_data_keep", 32'(rx_data_o), 32'h11);
        chk("t4_vrise", 32'(vrise), 2);
        repeat (20) @(negedge clk);

        // 5: back-to-back frames
        v0 = vrise;
        h0 = vhigh;
        send(8'h00, 1'b1);
        r0 = last_vrise;
        chk("t5_data0", 32'(rx_data_o), 32'h00);
        send(8'hFF, 1'b1);
        chk("t5_data1", 32'(rx_data_o), 32'hFF);
        chk("t5_spacing", 32'(last_vrise - r0), 10 * CPB);
        chk("t5_vrise", 32'(vrise - v0), 2);
        chk("t5_vwidth", 32'(vhigh - h0), 2);
        repeat (20) @(negedge clk);

        // 6: reset during data bit 3 of 0x5A (bits LSB first: 0,1,0,1)
        f0 = fe_n;
        o0 = ov_n;
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_i = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        chk("t6_busy_pre", 32'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", 32'(busy_o), 0);
        chk("t6_data", 32'(rx_data_o), 0);
        chk("t6_valid", 32'(rx_valid_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rx_i = 1'b1;
        repeat (20) @(negedge clk);
        v0 = vrise;
        send(8'h5A, 1'b1);
        chk("t6_data_new", 32'(rx_data_o), 32'h5A);
        chk("t6_vrise", 32'(vrise - v0), 1);
        chk("t6_latency", 32'(last_vrise - t_start), LAT);
        chk("t6_no_err", 32'(fe_n - f0 + ov_n - o0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
